sr_lsu: RTL and testbench

Load/store unit sitting directly downstream of the core's data-memory port. It takes byte/half/word load and store requests, including sign/zero extension controls. It turns each request into one or two word-wide transactions on a variable-latency memory bus with byte enables. The loaded value is returned to the core, already aligned and extended, with a completion pulse.

---
 rtl/sr_lsu.sv | 242 ++++++++++++++++++++++++
 tb/tb_sr_lsu.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_lsu.sv
// sr_lsu: load/store unit between the core data port and a word-wide,
// variable-latency memory bus with byte enables.
//   Core side : cpu_req/cpu_we/cpu_addr/cpu_wdata, size select w_byte/w_half/w_word,
//               sign; returns cpu_ready (comb), cpu_done, cpu_rdata, cpu_err.
//   Bus side  : mem_req/mem_we/mem_addr/mem_be/mem_wdata out, mem_rdata/mem_ack in.
// Build option: define SR_LSU_MISALIGN_EN to perform word-crossing accesses as two
// bus transactions; without it such requests complete immediately with cpu_err.
module sr_lsu #(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic          w_byte,
    input  logic          w_half,
    input  logic          w_word,
    input  logic          sign,
    output logic          cpu_ready,
    output logic          cpu_done,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} stateT;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} sizeT;

    stateT         state, stateNext;

    // request decode
    sizeT          sizeIn;
    logic [7:0]    maskIn;
    logic [7:0]    be64In;
    logic [63:0]   laneMask;
    logic [63:0]   wd64In;
    logic [AW-1:0] widxIn;
    logic          splitIn;
    logic          rejectIn;
    logic          unusedBits;

    // latched request
    logic          reqWe;
    logic          reqSign;
    logic [1:0]    reqOff;
    sizeT          reqSize;
    logic          reqSplit;
    logic [AW-1:0] reqAddrHi;
    logic [3:0]    reqBeHi;
    logic [31:0]   reqWdHi;
    logic [31:0]   loQ;

    // next-state values of registered outputs
    logic          memReqNext;
    logic          memWeNext;
    logic [AW-1:0] memAddrNext;
    logic [3:0]    memBeNext;
    logic [31:0]   memWdataNext;
    logic          doneNext;
    logic          errNext;
    logic [31:0]   rdataNext;

    // Size decode (byte > half > word, none = word) and 64-bit lane placement
    always_comb begin
        if (w_byte) begin
            sizeIn = SZ_BYTE;
            maskIn = 8'h01;
        end else if (w_half) begin
            sizeIn = SZ_HALF;
            maskIn = 8'h03;
        end else begin
            sizeIn = SZ_WORD;
            maskIn = 8'h0F;
        end
        be64In = maskIn << cpu_addr[1:0];
        for (int i = 0; i < 8; i++) begin
            laneMask[8*i +: 8] = {8{be64In[i]}};
        end
        // unused lanes forced to zero so stray high bits of cpu_wdata never reach the bus
        wd64In = ({32'h0, cpu_wdata} << {cpu_addr[1:0], 3'b000}) & laneMask;
    end

    assign widxIn  = cpu_addr[AW+1:2];
    assign splitIn = |be64In[7:4];

`ifdef SR_LSU_MISALIGN_EN
    assign rejectIn = 1'b0;
`else
    assign rejectIn = splitIn;
`endif

    // address bits above the bus range and w_word (implied default) carry no information
    assign unusedBits = ^{cpu_addr[31:AW+2], w_word};

    assign cpu_ready = (state == IDLE);

    // Align the fetched word pair, truncate to the access size and extend
    function automatic logic [31:0] loadResult(input logic [63:0] pair, input logic [1:0] off,
                                               input sizeT size, input logic sgn);
        logic [31:0] r;
        r = 32'(pair >> {off, 3'b000});
        case (size)
            SZ_BYTE: return {{24{sgn & r[7]}}, r[7:0]};
            SZ_HALF: return {{16{sgn & r[15]}}, r[15:0]};
            default: return r;
        endcase
    endfunction

    // Request latch and low-word capture
    always_ff @(posedge clk) begin
        if (rst) begin
            reqWe     <= 1'b0;
            reqSign   <= 1'b0;
            reqOff    <= 2'b00;
            reqSize   <= SZ_WORD;
            reqSplit  <= 1'b0;
            reqAddrHi <= '0;
            reqBeHi   <= 4'h0;
            reqWdHi   <= 32'h0;
            loQ       <= 32'h0;
        end else begin
            if (state == IDLE && cpu_req) begin
                reqWe     <= cpu_we;
                reqSign   <= sign;
                reqOff    <= cpu_addr[1:0];
                reqSize   <= sizeIn;
                reqSplit  <= splitIn;
                reqAddrHi <= AW'(widxIn + AW'(1));
                reqBeHi   <= be64In[7:4];
                reqWdHi   <= wd64In[63:32];
            end
            if (state == ACC0 && mem_ack) begin
                loQ <= mem_rdata;
            end
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'h0;
            mem_wdata <= 32'h0;
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= 32'h0;
        end else begin
            state     <= stateNext;
            mem_req   <= memReqNext;
            mem_we    <= memWeNext;
            mem_addr  <= memAddrNext;
            mem_be    <= memBeNext;
            mem_wdata <= memWdataNext;
            cpu_done  <= doneNext;
            cpu_err   <= errNext;
            cpu_rdata <= rdataNext;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        stateNext    = state;
        memReqNext   = mem_req;
        memWeNext    = mem_we;
        memAddrNext  = mem_addr;
        memBeNext    = mem_be;
        memWdataNext = mem_wdata;
        doneNext     = 1'b0;
        errNext      = 1'b0;
        rdataNext    = cpu_rdata;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (rejectIn) begin
                        stateNext = DONE;
                        doneNext  = 1'b1;
                        errNext   = 1'b1;
                    end else begin
                        stateNext    = ACC0;
                        memReqNext   = 1'b1;
                        memWeNext    = cpu_we;
                        memAddrNext  = widxIn;
                        // loads fetch the whole word; lane selection happens on return
                        memBeNext    = cpu_we ? be64In[3:0] : 4'hF;
                        memWdataNext = cpu_we ? wd64In[31:0] : 32'h0;
                    end
                end
            end
            ACC0: begin
                if (mem_ack) begin
                    if (reqSplit) begin
                        stateNext    = ACC1;
                        memAddrNext  = reqAddrHi;
                        memBeNext    = reqWe ? reqBeHi : 4'hF;
                        memWdataNext = reqWe ? reqWdHi : 32'h0;
                    end else begin
                        stateNext    = DONE;
                        memReqNext   = 1'b0;
                        memWeNext    = 1'b0;
                        memBeNext    = 4'h0;
                        memWdataNext = 32'h0;
                        doneNext     = 1'b1;
                        if (!reqWe) begin
                            rdataNext = loadResult({32'h0, mem_rdata}, reqOff, reqSize, reqSign);
                        end
                    end
                end
            end
            ACC1: begin
                if (mem_ack) begin
                    stateNext    = DONE;
                    memReqNext   = 1'b0;
                    memWeNext    = 1'b0;
                    memBeNext    = 4'h0;
                    memWdataNext = 32'h0;
                    doneNext     = 1'b1;
                    if (!reqWe) begin
                        rdataNext = loadResult({mem_rdata, loQ}, reqOff, reqSize, reqSign);
                    end
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sr_lsu.sv
// tb_sr_lsu: directed bench for sr_lsu with a 256-word bus memory responder
// (programmable ack delay, forced stray acks) and immediate-assertion checks.
// Expectations for word-crossing accesses follow SR_LSU_MISALIGN_EN.
module tb_sr_lsu;

    localparam int unsigned AW = 8;
    localparam logic [2:0] SZB = 3'b001;
    localparam logic [2:0] SZH = 3'b010;
    localparam logic [2:0] SZW = 3'b100;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req;
    logic          cpu_we;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          w_byte;
    logic          w_half;
    logic          w_word;
    logic          sign;
    logic          cpu_ready;
    logic          cpu_done;
    logic [31:0]   cpu_rdata;
    logic          cpu_err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_ack;

    sr_lsu #(.AW(AW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .w_byte(w_byte), .w_half(w_half), .w_word(w_word), .sign(sign),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // bus memory model
    logic [31:0] mem [0:255];
    int          ackDelay = 0;
    logic        ackForce = 1'b0;
    int          waitCnt = 0;
    logic        memClear = 1'b0;
    logic        pokeEn = 1'b0;
    logic [7:0]  pokeAddr = 8'h0;
    logic [31:0] pokeData = 32'h0;
    int          doneCnt = 0;
    int          errCnt = 0;
    int          reqCycles = 0;
    int          txnCnt = 0;
    logic [7:0]  logAddr [0:15];
    logic [3:0]  logBe [0:15];
    logic [31:0] logWd [0:15];
    logic        logWe [0:15];

    int checks = 0;
    int errors = 0;

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = ackForce | (mem_req && (waitCnt >= ackDelay));

    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end
        if (pokeEn) mem[pokeAddr] <= pokeData;
        if (cpu_done) doneCnt <= doneCnt + 1;
        if (cpu_err) errCnt <= errCnt + 1;
        if (!rst && mem_req) begin
            reqCycles <= reqCycles + 1;
            if (mem_ack) begin
                logAddr[4'(txnCnt)] <= mem_addr;
                logBe[4'(txnCnt)]   <= mem_be;
                logWd[4'(txnCnt)]   <= mem_wdata;
                logWe[4'(txnCnt)]   <= mem_we;
                txnCnt  <= txnCnt + 1;
                waitCnt <= 0;
                for (int i = 0; i < 4; i++) begin
                    if (mem_we && mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end else begin
                waitCnt <= waitCnt + 1;
            end
        end else begin
            waitCnt <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pokeAddr = a;
        pokeData = d;
        pokeEn   = 1'b1;
        @(negedge clk);
        pokeEn   = 1'b0;
    endtask

    // Issue one request, scramble the request inputs after acceptance, wait for cpu_done.
    // With hold set, cpu_req stays high while waiting and the bus outputs are checked each cycle.
    task automatic runOp(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [2:0] size, input logic sgn,
                         input bit hold, input logic [7:0] expAddr,
                         output int lat, output logic firstReq);
        bit seen;
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        {w_word, w_half, w_byte} = size;
        sign      = sgn;
        check({tag, "_ready_in"}, 32'(cpu_ready), 32'h1);
        @(posedge clk);
        lat      = 0;
        seen     = 1'b0;
        firstReq = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                firstReq  = mem_req;
                cpu_req   = hold;
                cpu_addr  = ~addr;
                cpu_wdata = ~wd;
                sign      = ~sgn;
            end
            if (cpu_done) begin
                seen = 1'b1;
            end else if (hold) begin
                check({tag, "_hold_req"}, 32'(mem_req), 32'h1);
                check({tag, "_hold_addr"}, 32'(mem_addr), 32'(expAddr));
                check({tag, "_hold_be"}, 32'(mem_be), 32'hF);
                check({tag, "_hold_ready"}, 32'(cpu_ready), 32'h0);
            end
        end
        cpu_req = 1'b0;
        if (!seen) begin
            lat = -1;
            check({tag, "_done_timeout"}, 32'h0, 32'h1);
        end
    endtask

    // Checks common to every completion, taken in the cpu_done cycle and the one after
    task automatic opDone(input string tag, input int lat, input int expLat, input logic expErr,
                          input logic [31:0] expRdata, input int doneBase);
        check({tag, "_latency"}, 32'(lat), 32'(expLat));
        check({tag, "_ready_done"}, 32'(cpu_ready), 32'h0);
        check({tag, "_err"}, 32'(cpu_err), 32'(expErr));
        check({tag, "_rdata"}, cpu_rdata, expRdata);
        @(negedge clk);
        check({tag, "_pulse_end"}, 32'(cpu_done), 32'h0);
        check({tag, "_done_count"}, 32'(doneCnt - doneBase), 32'h1);
    endtask

    initial begin
        int   lat;
        logic fr;
        int   db, eb, tb0, rb;

        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        w_byte = 1'b0; w_half = 1'b0; w_word = 1'b0; sign = 1'b0;
        memClear = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        memClear = 1'b0;
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_be", 32'(mem_be), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_done", 32'(cpu_done), 32'h0);
        check("rst_err", 32'(cpu_err), 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_ready", 32'(cpu_ready), 32'h1);
        rst = 1'b0;

        // signed byte load, lane 1 of word 5
        poke(8'd5, 32'h8899AABB);
        poke(8'd4, 32'h11223344);
        db = doneCnt; tb0 = txnCnt;
        runOp("t1", 1'b0, 32'h15, 32'h0, SZB, 1'b1, 1'b0, 8'd5, lat, fr);
        check("t1_req_n1", 32'(fr), 32'h1);
        opDone("t1", lat, 2, 1'b0, 32'hFFFFFFAA, db);
        check("t1_txns", 32'(txnCnt - tb0), 32'h1);
        check("t1_addr", 32'(logAddr[4'(tb0)]), 32'h5);
        check("t1_be", 32'(logBe[4'(tb0)]), 32'hF);
        check("t1_we", 32'(logWe[4'(tb0)]), 32'h0);

        // halfword store into the upper lanes of word 4
        db = doneCnt; tb0 = txnCnt;
        runOp("t2", 1'b1, 32'h12, 32'h1234ABCD, SZH, 1'b0, 1'b0, 8'd4, lat, fr);
        opDone("t2", lat, 2, 1'b0, 32'hFFFFFFAA, db);
        check("t2_txns", 32'(txnCnt - tb0), 32'h1);
        check("t2_addr", 32'(logAddr[4'(tb0)]), 32'h4);
        check("t2_be", 32'(logBe[4'(tb0)]), 32'hC);
        check("t2_wdata", logWd[4'(tb0)], 32'hABCD0000);
        check("t2_we", 32'(logWe[4'(tb0)]), 32'h1);
        check("t2_mem4", mem[4], 32'hABCD3344);

        // extension variants on the stored halfword
        db = doneCnt;
        runOp("t2b", 1'b0, 32'h13, 32'h0, SZB, 1'b0, 1'b0, 8'd4, lat, fr);
        opDone("t2b", lat, 2, 1'b0, 32'h000000AB, db);
        db = doneCnt;
        runOp("t2c", 1'b0, 32'h12, 32'h0, SZH, 1'b1, 1'b0, 8'd4, lat, fr);
        opDone("t2c", lat, 2, 1'b0, 32'hFFFFABCD, db);
        db = doneCnt;
        runOp("t2d", 1'b0, 32'h12, 32'h0, SZH, 1'b0, 1'b0, 8'd4, lat, fr);
        opDone("t2d", lat, 2, 1'b0, 32'h0000ABCD, db);

        // word load crossing words 3/4
        poke(8'd3, 32'h44332211);
        poke(8'd4, 32'h88776655);
        db = doneCnt; eb = errCnt; tb0 = txnCnt; rb = reqCycles;
        runOp("t3", 1'b0, 32'h0E, 32'h0, SZW, 1'b0, 1'b0, 8'd3, lat, fr);
`ifdef SR_LSU_MISALIGN_EN
        opDone("t3", lat, 3, 1'b0, 32'h66554433, db);
        check("t3_txns", 32'(txnCnt - tb0), 32'h2);
        check("t3_addr0", 32'(logAddr[4'(tb0)]), 32'h3);
        check("t3_addr1", 32'(logAddr[4'(tb0 + 1)]), 32'h4);
        check("t3_be0", 32'(logBe[4'(tb0)]), 32'hF);
        check("t3_be1", 32'(logBe[4'(tb0 + 1)]), 32'hF);
`else
        check("t3_req_n1", 32'(fr), 32'h0);
        opDone("t3", lat, 1, 1'b1, 32'h0000ABCD, db);
        check("t3_txns", 32'(txnCnt - tb0), 32'h0);
        check("t3_req_cycles", 32'(reqCycles - rb), 32'h0);
        check("t3_err_count", 32'(errCnt - eb), 32'h1);
`endif

        // delayed ack with cpu_req held high and inputs changing after acceptance
        ackDelay = 3;
        db = doneCnt; tb0 = txnCnt; rb = reqCycles;
        runOp("t4", 1'b0, 32'h0C, 32'h0, SZW, 1'b0, 1'b1, 8'd3, lat, fr);
        opDone("t4", lat, 5, 1'b0, 32'h44332211, db);
        repeat (3) @(negedge clk);
        check("t4_done_total", 32'(doneCnt - db), 32'h1);
        check("t4_txns", 32'(txnCnt - tb0), 32'h1);
        check("t4_req_cycles", 32'(reqCycles - rb), 32'h4);
        ackDelay = 0;

        // word store wrapping from word 255 to word 0
        poke(8'd255, 32'h11111111);
        poke(8'd0, 32'h22222222);
        db = doneCnt; eb = errCnt; tb0 = txnCnt;
        runOp("t5", 1'b1, 32'h3FE, 32'hDDCCBBAA, SZW, 1'b0, 1'b0, 8'd255, lat, fr);
`ifdef SR_LSU_MISALIGN_EN
        opDone("t5", lat, 3, 1'b0, 32'h44332211, db);
        check("t5_txns", 32'(txnCnt - tb0), 32'h2);
        check("t5_addr0", 32'(logAddr[4'(tb0)]), 32'hFF);
        check("t5_be0", 32'(logBe[4'(tb0)]), 32'hC);
        check("t5_wd0", logWd[4'(tb0)], 32'hBBAA0000);
        check("t5_addr1", 32'(logAddr[4'(tb0 + 1)]), 32'h0);
        check("t5_be1", 32'(logBe[4'(tb0 + 1)]), 32'h3);
        check("t5_wd1", logWd[4'(tb0 + 1)], 32'h0000DDCC);
        check("t5_mem255", mem[255], 32'hBBAA1111);
        check("t5_mem0", mem[0], 32'h2222DDCC);
`else
        opDone("t5", lat, 1, 1'b1, 32'h44332211, db);
        check("t5_txns", 32'(txnCnt - tb0), 32'h0);
        check("t5_err_count", 32'(errCnt - eb), 32'h1);
        check("t5_mem255", mem[255], 32'h11111111);
        check("t5_mem0", mem[0], 32'h22222222);
`endif

        // byte store: stray high data bits must not reach other lanes
        db = doneCnt; tb0 = txnCnt;
        runOp("t5b", 1'b1, 32'h01, 32'hFFFFFF5A, SZB, 1'b0, 1'b0, 8'd0, lat, fr);
        opDone("t5b", lat, 2, 1'b0, 32'h44332211, db);
        check("t5b_be", 32'(logBe[4'(tb0)]), 32'h2);
        check("t5b_wdata", logWd[4'(tb0)], 32'h00005A00);
`ifdef SR_LSU_MISALIGN_EN
        check("t5b_mem0", mem[0], 32'h22225ACC);
`else
        check("t5b_mem0", mem[0], 32'h22225A22);
`endif

        // reset while the first access waits for its ack, then stray acks while idle
        ackDelay = 5;
        db = doneCnt; tb0 = txnCnt;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; {w_word, w_half, w_byte} = SZW; sign = 1'b0;
`ifdef SR_LSU_MISALIGN_EN
        cpu_addr = 32'h0E;
`else
        cpu_addr = 32'h0C;
`endif
        @(negedge clk);
        check("t6_req_acc0", 32'(mem_req), 32'h1);
        cpu_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_req_after_rst", 32'(mem_req), 32'h0);
        check("t6_be_after_rst", 32'(mem_be), 32'h0);
        check("t6_ready_after_rst", 32'(cpu_ready), 32'h1);
        ackDelay = 0;
        ackForce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_stray_done", 32'(cpu_done), 32'h0);
            check("t6_stray_ready", 32'(cpu_ready), 32'h1);
        end
        ackForce = 1'b0;
        @(negedge clk);
        check("t6_done_total", 32'(doneCnt - db), 32'h0);
        check("t6_txns", 32'(txnCnt - tb0), 32'h0);

        // recovery after reset
        db = doneCnt;
        runOp("t7", 1'b0, 32'h17, 32'h0, SZB, 1'b1, 1'b0, 8'd5, lat, fr);
        opDone("t7", lat, 2, 1'b0, 32'hFFFFFF88, db);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
